// File: rtl/acpo_readback_ctrl_if.sv
// acpo_readback_ctrl_if: valid/ready result stream toward the next-layer loader.
// master = readback controller, slave = loader.
interface acpo_readback_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_ready_i;

    modport master (
        output out_valid_o,
        output out_data_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        output out_ready_i
    );
endinterface

// File: rtl/acpo_readback_ctrl.sv
// acpo_readback_ctrl: drains SA/FC result BRAMs into a credit-limited stream FIFO.
// Optional pool-address sideband enabled by defining ACPO_RB_ADDR_EN.
module acpo_readback_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_PTR_W   = 14,
    parameter int FC_PTR_W   = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int BRAM_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  mode_fc_i,
    input  logic [SA_PTR_W-1:0]   base_ptr_i,
    input  logic [SA_PTR_W:0]     len_i,
    input  logic [15:0]           pool_last_i,
    input  logic                  act_last_i,
    output logic                  sa_rden_o,
    output logic [SA_PTR_W-1:0]   sa_rdptr_o,
    input  logic [DATA_WIDTH-1:0] sa_rdata_i,
    output logic                  fc_rden_o,
    output logic [FC_PTR_W-1:0]   fc_rdptr_o,
    input  logic [DATA_WIDTH-1:0] fc_rdata_i,
`ifdef ACPO_RB_ADDR_EN
    output logic                  pool_addr_rden_o,
    output logic [SA_PTR_W-1:0]   pool_addr_rdptr_o,
    input  logic [9:0]            pool_addr_rdata_i,
    output logic [9:0]            out_addr_o,
`endif
    acpo_readback_ctrl_if.master  out_if,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = SA_PTR_W + 1;
`ifdef ACPO_RB_ADDR_EN
    localparam int EW = DATA_WIDTH + 10;
`else
    localparam int EW = DATA_WIDTH;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]          state;
    logic                mode_fc;
    logic                act_seen;
    logic [SA_PTR_W-1:0] ptr;
    logic [LW-1:0]       len;
    logic [LW-1:0]       issued;
    logic [LW-1:0]       popped;
    logic [15:0]         mask;
    logic [15:0]         mask_nx;
    logic [BRAM_LAT-1:0] rd_pipe;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       count;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [EW-1:0]       wr_entry;
    logic                issue;
    logic                push;
    logic                pop;
    logic                valid;
    logic                wait_exit;

    assign mask_nx   = mask | pool_last_i;
    assign wait_exit = (state == S_WAIT) &&
                       (mode_fc ? (act_seen | act_last_i)
                                : (mask_nx == 16'hFFFF));

    // Credit covers both buffered words and reads still in the BRAM pipe.
    assign issue = (state == S_READ) &&
                   ((count + inflight) < CW'(FIFO_DEPTH));
    assign push  = rd_pipe[BRAM_LAT-1];
    assign valid = (count != '0);
    assign pop   = valid && out_if.out_ready_i;

    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_DRAIN) &&
                    ((len == '0) || (pop && ((popped + LW'(1)) == len)));

    assign sa_rden_o  = issue && !mode_fc;
    assign fc_rden_o  = issue && mode_fc;
    assign sa_rdptr_o = sa_rden_o ? ptr : '0;
    assign fc_rdptr_o = fc_rden_o ? ptr[FC_PTR_W-1:0] : '0;

`ifdef ACPO_RB_ADDR_EN
    assign pool_addr_rden_o  = sa_rden_o;
    assign pool_addr_rdptr_o = sa_rdptr_o;
    assign wr_entry = {(mode_fc ? 10'd0 : pool_addr_rdata_i),
                       (mode_fc ? fc_rdata_i : sa_rdata_i)};
    assign out_addr_o = valid ? mem[rd_ptr][EW-1:DATA_WIDTH] : '0;
`else
    assign wr_entry = mode_fc ? fc_rdata_i : sa_rdata_i;
`endif

    assign out_if.out_valid_o = valid;
    assign out_if.out_data_o  = valid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;

    // Sequencer: latch the job, wait for completion, issue reads, drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode_fc  <= 1'b0;
            act_seen <= 1'b0;
            ptr      <= '0;
            len      <= '0;
            issued   <= '0;
            popped   <= '0;
            mask     <= '0;
        end else begin
            if (pop) popped <= popped + LW'(1);
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state    <= S_WAIT;
                        mode_fc  <= mode_fc_i;
                        ptr      <= base_ptr_i;
                        len      <= len_i;
                        issued   <= '0;
                        popped   <= '0;
                        mask     <= pool_last_i;
                        act_seen <= act_last_i;
                    end
                end
                S_WAIT: begin
                    mask <= mask_nx;
                    if (wait_exit)
                        state <= (len == '0) ? S_DRAIN : S_READ;
                end
                S_READ: begin
                    if (issue) begin
                        ptr    <= ptr + SA_PTR_W'(1);
                        issued <= issued + LW'(1);
                        if ((issued + LW'(1)) == len) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (done_o) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    generate
        if (BRAM_LAT == 1) begin : g_lat1
            // Read-enable delay line marking when BRAM data becomes valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rd_pipe <= '0;
                else        rd_pipe <= issue;
            end
        end else begin : g_latn
            // Read-enable delay line marking when BRAM data becomes valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rd_pipe <= '0;
                else        rd_pipe <= {rd_pipe[BRAM_LAT-2:0], issue};
            end
        end
    endgenerate

    // FIFO bookkeeping and in-flight read count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(push);
            count    <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // FIFO storage; a push into a full FIFO would mean broken credit.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
        if (rst_n) assert (!(push && !pop && count == CW'(FIFO_DEPTH)));
    end
endmodule
